// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
// core_mem_pkg
// Shared types and default constants for the core memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package core_mem_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int ID_W_DEF      = 3;
   localparam int MEM_WORDS_DEF = 256;
   localparam int LATENCY_DEF   = 4;
   localparam int QDEPTH_DEF    = 4;

   typedef enum logic {
      RESP_IDLE = 1'b0,
      RESP_BUSY = 1'b1
   } resp_state_t;

   // Request as seen on the core interface at the default widths
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
      logic                  rw;
      logic [ID_W_DEF-1:0]   id;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/core_mem_responder_req_fifo.sv
`default_nettype none
// ============================================================================
// req_fifo
// Synchronous in-order request FIFO; pointers wrap modulo DEPTH (power of 2).
// Revision: 1.0 - initial release
// ============================================================================
module req_fifo
   import core_mem_pkg::*;
#(
   parameter type T     = req_t,
   parameter int  DEPTH = QDEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  T                         data_i,
   input  logic                     pop_i,
   output T                         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              store_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // Entry storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push_i) begin
         store_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = store_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// ============================================================================
// core_mem_responder
// Memory-side responder for the core request interface: queues requests in
// order and services each from on-chip word memory with fixed latency.
// Optional build macro: CORE_MEM_RESP_WRITE_ACK_EN (writes also strobe
// ready_out with the written data).
// Revision: 1.0 - initial release
// ============================================================================
module core_mem_responder
   import core_mem_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ID_W      = ID_W_DEF,
   parameter int MEM_WORDS = MEM_WORDS_DEF,
   parameter int LATENCY   = LATENCY_DEF,
   parameter int QDEPTH    = QDEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rw_in,
   input  logic              valid_in,
   input  logic [ID_W-1:0]   id_in,
   output logic [DATA_W-1:0] data_out,
   output logic [ID_W-1:0]   id_out,
   output logic              ready_out,
   output logic              stall_out
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int QCW   = $clog2(QDEPTH) + 1;

   // Queued request; the address is kept as the word index only
   typedef struct packed {
      logic [IDX_W-1:0]  addr;
      logic [DATA_W-1:0] data;
      logic              rw;
      logic [ID_W-1:0]   id;
   } entry_t;

   entry_t            push_entry;
   entry_t            head;
   logic              push;
   logic              pop;
   logic              q_full;
   logic              q_empty;
   logic [QCW-1:0]    q_count;
   logic              execute;
   logic              more_after_pop;

   resp_state_t       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mem [MEM_WORDS];

   // Byte offset and bits above the memory size alias away
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_in[ADDR_W-1:IDX_W+2], addr_in[1:0]};

   assign push_entry = '{addr: addr_in[IDX_W+1:2], data: data_in, rw: rw_in, id: id_in};

   // stall_out comes straight from the registered occupancy, so a push is
   // blocked while full even in a cycle where the head is popped
   assign stall_out      = q_full;
   assign push           = valid_in && !q_full;
   assign execute        = (state_q == RESP_BUSY) && (cnt_q == '0);
   assign pop            = execute;
   assign more_after_pop = (q_count > QCW'(1)) || push;

   req_fifo #(
      .T     (entry_t),
      .DEPTH (QDEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   // Word memory write at execute; a write coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (reset && execute && head.rw) begin
         mem[head.addr] <= head.data;
      end
   end

   // Service FSM: wait out the latency, then execute the head and strobe
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RESP_IDLE;
         cnt_q     <= '0;
         data_out  <= '0;
         id_out    <= '0;
         ready_out <= 1'b0;
      end else begin
         ready_out <= 1'b0;
         case (state_q)
            RESP_IDLE: begin
               if (!q_empty) begin
                  state_q <= RESP_BUSY;
                  cnt_q   <= CNT_W'(LATENCY - 2);
               end
            end
            RESP_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  if (!head.rw) begin
                     data_out  <= mem[head.addr];
                     id_out    <= head.id;
                     ready_out <= 1'b1;
                  end
`ifdef CORE_MEM_RESP_WRITE_ACK_EN
                  else begin
                     data_out  <= head.data;
                     id_out    <= head.id;
                     ready_out <= 1'b1;
                  end
`endif
                  if (more_after_pop) begin
                     cnt_q <= CNT_W'(LATENCY - 1);
                  end else begin
                     state_q <= RESP_IDLE;
                  end
               end
            end
            default: state_q <= RESP_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_core_mem_responder
// Scoreboard bench: issued requests push expected responses, a negedge
// monitor pops and compares on every ready_out strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_mem_responder;

   localparam int LAT = 4;
`ifdef CORE_MEM_RESP_WRITE_ACK_EN
   localparam int ACK = 1;
`else
   localparam int ACK = 0;
`endif

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic [31:0] addr_in  = '0;
   logic [31:0] data_in  = '0;
   logic        rw_in    = 1'b0;
   logic        valid_in = 1'b0;
   logic [2:0]  id_in    = '0;
   logic [31:0] data_out;
   logic [2:0]  id_out;
   logic        ready_out;
   logic        stall_out;

   always #5 clk = ~clk;

   core_mem_responder #(
      .ADDR_W(32), .DATA_W(32), .ID_W(3), .MEM_WORDS(256), .LATENCY(LAT), .QDEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .rw_in(rw_in),
      .valid_in(valid_in), .id_in(id_in), .data_out(data_out), .id_out(id_out),
      .ready_out(ready_out), .stall_out(stall_out)
   );

   typedef struct {
      logic [31:0] data;
      logic [2:0]  id;
      int          due;
      bit          is_read;
      bit          eq;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [int];
   int n_checks    = 0;
   int n_fail      = 0;
   int cyc         = 0;
   int strobes     = 0;
   int stall_rises = 0;
   int read_sum    = 0;
   bit prev_stall  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin : mon
      exp_t e;
      if (stall_out && !prev_stall) stall_rises++;
      prev_stall = stall_out;
      if (reset && ready_out) begin
         strobes++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got id %0d data 0x%0h, expected no strobe", id_out, data_out);
         end else begin
            e = exp_q.pop_front();
            check("strobe_id", {29'd0, id_out}, {29'd0, e.id});
            if (e.eq) begin
               check("strobe_data", data_out, e.data);
            end else begin
               n_checks++;
               if (data_out === e.data) begin
                  n_fail++;
                  $display("FAIL reset_write_blocked: got 0x%0h, required any value but 0x%0h", data_out, e.data);
               end
            end
            if (e.due >= 0) check("strobe_cycle", 32'(cyc), 32'(e.due));
            if (e.is_read) read_sum += int'(data_out);
         end
      end
   end

   // Drive one request, hold it while stalled, return the accepting cycle
   task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] id, input int due_off, output int acc);
      int   waits;
      int   idx;
      exp_t e;
      valid_in = 1'b1; rw_in = rw; addr_in = a; data_in = d; id_in = id;
      waits = 0;
      while (stall_out === 1'b1 && waits < 200) begin
         @(posedge clk); #1;
         waits++;
      end
      if (stall_out !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got stall_out %b, expected 0", stall_out);
      end
      @(posedge clk); #1;
      acc      = cyc;
      valid_in = 1'b0;
      idx      = int'(a[9:2]);
      e.id     = id;
      e.due    = (due_off >= 0) ? acc + due_off : -1;
      if (!rw) begin
         // An unwritten word may hold anything except the blocked reset write
         e.eq      = model.exists(idx);
         e.data    = model.exists(idx) ? model[idx] : 32'h0000_DEAD;
         e.is_read = 1'b1;
         exp_q.push_back(e);
      end else begin
         model[idx] = d;
         if (ACK != 0) begin
            e.eq      = 1'b1;
            e.data    = d;
            e.is_read = 1'b0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(posedge clk);
         w++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, wacc, racc, a0, rel, s0;

      // Reset held with a write request present
      reset = 1'b0; valid_in = 1'b1; rw_in = 1'b1; addr_in = 32'h20; data_in = 32'hDEAD; id_in = 3'd5;
      repeat (5) begin
         @(negedge clk);
         check("reset_ready", {31'd0, ready_out}, 32'd0);
         check("reset_stall", {31'd0, stall_out}, 32'd0);
      end
      check("reset_data_out", data_out, 32'd0);
      check("reset_id_out", {29'd0, id_out}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; valid_in = 1'b0;
      rel = cyc;

      // Write then read-after-write; strobe 2*LAT after the write accept
      issue(1'b1, 32'h10, 32'h5A, 3'd0, LAT, wacc);
      check("first_accept_cycle", 32'(wacc), 32'(rel + 1));
      issue(1'b0, 32'h10, 32'h0, 3'd3, 2 * LAT - 1, racc);
      check("raw_accept_gap", 32'(racc - wacc), 32'd1);
      issue(1'b0, 32'h20, 32'h0, 3'd1, -1, acc);
      drain();

      // 64 writes then 64 reads under continuous valid
      s0 = strobes; read_sum = 0; stall_rises = 0;
      for (int k = 0; k < 64; k++) issue(1'b1, 32'(4 * k), 32'(k), 3'(k % 8), -1, acc);
      for (int k = 0; k < 64; k++) issue(1'b0, 32'(4 * k), 32'h0, 3'(k % 8), -1, acc);
      drain();
      check("bulk_strobe_count", 32'(strobes - s0), 32'(64 + 64 * ACK));
      check("bulk_read_sum", 32'(read_sum), 32'd2016);
      check("bulk_stall_toggled", {31'd0, stall_rises > 0}, 32'd1);

      // Fill the queue, then the 5th push lands one cycle after the first pop
      issue(1'b0, 32'h0, 32'h0, 3'd4, LAT, a0);
      issue(1'b0, 32'h4, 32'h0, 3'd5, 2 * LAT - 1, acc);
      issue(1'b0, 32'h8, 32'h0, 3'd6, 3 * LAT - 2, acc);
      check("fill3_stall", {31'd0, stall_out}, 32'd0);
      issue(1'b0, 32'hC, 32'h0, 3'd7, 4 * LAT - 3, acc);
      check("fill4_accept_cycle", 32'(acc), 32'(a0 + 3));
      check("fill4_stall", {31'd0, stall_out}, 32'd1);
      issue(1'b0, 32'h10, 32'h0, 3'd2, 5 * LAT - (LAT + 1), acc);
      check("fifth_accept_cycle", 32'(acc), 32'(a0 + LAT + 1));
      drain();

      // Address aliasing
      issue(1'b1, 32'h004, 32'h77, 3'd0, -1, acc);
      issue(1'b0, 32'h404, 32'h0, 3'd1, -1, acc);
      issue(1'b0, 32'h007, 32'h0, 3'd2, -1, acc);
      drain();
      check("alias_model_value", model[1], 32'h77);

      // Reset with three queued reads discards them silently
      issue(1'b0, 32'h0, 32'h0, 3'd1, -1, acc);
      issue(1'b0, 32'h4, 32'h0, 3'd2, -1, acc);
      issue(1'b0, 32'h8, 32'h0, 3'd3, -1, acc);
      reset = 1'b0;
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         check("midreset_ready", {31'd0, ready_out}, 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_reset_stall", {31'd0, stall_out}, 32'd0);
      issue(1'b0, 32'h8, 32'h0, 3'd6, LAT, acc);
      drain();
      issue(1'b1, 32'h8, 32'h9, 3'd5, LAT, acc);
      issue(1'b0, 32'h8, 32'h0, 3'd4, -1, acc);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
